// File: rtl/mbit_sel_wr_if.sv
// Request/status bundle for the sequential part-select writer.
// The requester drives the field, the writer returns the register and status.
interface mbit_sel_wr_if #(
  parameter int LO = 1,
  parameter int HI = 4,
  parameter int DW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_msb;
  logic [7:0]    req_lsb;
  logic [DW-1:0] req_data;
  logic [HI:LO]  reg_q;
  logic          busy;
  logic          done;
  logic          err;
  logic [3:0]    clip_cnt;

  modport master (
    output req_valid, req_msb, req_lsb, req_data,
    input  req_ready, reg_q, busy, done, err, clip_cnt
  );

  modport slave (
    input  req_valid, req_msb, req_lsb, req_data,
    output req_ready, reg_q, busy, done, err, clip_cnt
  );
endinterface

// File: rtl/mbit_sel_wr.sv
// Writes a [msb:lsb] field into a [HI:LO] register one bit per cycle;
// out-of-range bits are dropped and counted, malformed fields rejected.
module mbit_sel_wr #(
  parameter int LO = 1,
  parameter int HI = 4,
  parameter int DW = 4
) (
  input  logic       clock,
  input  logic       reset,
  mbit_sel_wr_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic signed [8:0] P_LO = 9'(LO);
  localparam logic signed [8:0] P_HI = 9'(HI);
  localparam logic signed [9:0] P_DW = 10'(DW);

  state_t r_state;
  state_t w_next;

  logic signed [8:0] r_msb;
  logic signed [8:0] r_lsb;
  logic signed [8:0] r_k;
  logic [DW-1:0]     r_data;
  logic [3:0]        r_clip;
  logic              r_err;
  logic [HI:LO]      r_q;

  logic signed [8:0] w_msb;
  logic signed [8:0] w_lsb;
  logic signed [9:0] w_wid;
  logic              w_acc;
  logic              w_bad;
  logic              w_in;
  logic              w_last;
  logic [8:0]        w_off;
  logic [DW-1:0]     w_dsh;
  logic              w_bit;

  // Indices are widened so negative values and k+1 never wrap.
  assign w_msb = $signed({bus.req_msb[7], bus.req_msb});
  assign w_lsb = $signed({bus.req_lsb[7], bus.req_lsb});
  assign w_wid = $signed({w_msb[8], w_msb})
               - $signed({w_lsb[8], w_lsb})
               + 10'sd1;
  assign w_bad = (w_msb < w_lsb) || (w_wid > P_DW);
  assign w_acc = bus.req_valid && (r_state == S_IDLE);

  assign w_in   = (r_k >= P_LO) && (r_k <= P_HI);
  assign w_last = (r_k == r_msb);
  assign w_off  = 9'(r_k - r_lsb);
  assign w_dsh  = r_data >> w_off;
  assign w_bit  = w_dsh[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = w_bad ? S_DONE : S_WRITE;
      S_WRITE: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q    <= '0;
      r_clip <= '0;
      r_err  <= 1'b0;
      r_msb  <= '0;
      r_lsb  <= '0;
      r_k    <= '0;
      r_data <= '0;
    end else if (w_acc) begin
      r_msb  <= w_msb;
      r_lsb  <= w_lsb;
      r_k    <= w_lsb;
      r_data <= bus.req_data;
      r_clip <= '0;
      r_err  <= w_bad;
    end else if (r_state == S_WRITE) begin
      if (w_in) begin
        for (int b = LO; b <= HI; b++) begin
          if (r_k == 9'(b)) r_q[b] <= w_bit;
        end
      end else begin
        r_clip <= r_clip + 4'd1;
      end
      r_k <= r_k + 9'sd1;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_WRITE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.clip_cnt  = r_clip;
  assign bus.reg_q     = r_q;

endmodule

// File: tb/tb_mbit_sel_wr.sv
// Randomised and directed checks of mbit_sel_wr against a
// field-level reference model of the target register.
module tb_mbit_sel_wr;

  localparam int LO = 1;
  localparam int HI = 4;
  localparam int DW = 4;

  logic clock;
  logic reset;
  int   n_err;
  int   n_chk;
  logic [HI:LO] mq;

  mbit_sel_wr_if #(.LO(LO), .HI(HI), .DW(DW)) bus ();

  mbit_sel_wr #(.LO(LO), .HI(HI), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: apply the whole field to a copy of the register.
  task automatic model(input int msb, input int lsb,
                       input logic [DW-1:0] d,
                       output bit bad, output int n,
                       output int clip, output logic [HI:LO] eq);
    n    = msb - lsb + 1;
    bad  = (msb < lsb) || (n > DW);
    clip = 0;
    eq   = mq;
    if (!bad) begin
      for (int i = lsb; i <= msb; i++) begin
        if (i >= LO && i <= HI) eq[i] = d[i-lsb];
        else clip++;
      end
    end
  endtask

  task automatic run_req(input int msb, input int lsb,
                         input logic [DW-1:0] d);
    bit bad;
    int n;
    int clip;
    logic [HI:LO] eq;
    logic [HI:LO] pm;
    model(msb, lsb, d, bad, n, clip, eq);
    chk("ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_msb   = 8'(msb);
    bus.req_lsb   = 8'(lsb);
    bus.req_data  = d;
    tick();
    bus.req_valid = 1'b0;
    if (bad) begin
      chk("err_done", 32'(bus.done), 32'd1);
      chk("err_flag", 32'(bus.err), 32'd1);
      chk("err_busy", 32'(bus.busy), 32'd0);
      chk("err_q", 32'(bus.reg_q), 32'(mq));
      tick();
      chk("err_ready", 32'(bus.req_ready), 32'd1);
      chk("err_done_off", 32'(bus.done), 32'd0);
    end else begin
      pm = mq;
      for (int i = 0; i < n; i++) begin
        chk("wr_busy", 32'(bus.busy), 32'd1);
        chk("wr_done", 32'(bus.done), 32'd0);
        chk("wr_partial_q", 32'(bus.reg_q), 32'(pm));
        if (lsb + i >= LO && lsb + i <= HI) pm[lsb+i] = d[i];
        tick();
      end
      chk("done", 32'(bus.done), 32'd1);
      chk("done_err", 32'(bus.err), 32'd0);
      chk("done_clip", 32'(bus.clip_cnt), 32'(clip));
      chk("done_busy", 32'(bus.busy), 32'd0);
      chk("done_q", 32'(bus.reg_q), 32'(eq));
      tick();
      chk("idle_ready", 32'(bus.req_ready), 32'd1);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("hold_clip", 32'(bus.clip_cnt), 32'(clip));
      chk("hold_err", 32'(bus.err), 32'd0);
    end
    mq = eq;
  endtask

  int acc_cyc[$];
  int wait_n;

  initial begin
    n_err = 0;
    n_chk = 0;
    mq    = '0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_msb   = '0;
    bus.req_lsb   = '0;
    bus.req_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_q", 32'(bus.reg_q), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_clip", 32'(bus.clip_cnt), 32'd0);

    run_req(4, 1, 4'h4);
    chk("tp_q4", 32'(bus.reg_q), 32'h4);
    run_req(4, 1, 4'h8);
    chk("tp_q8", 32'(bus.reg_q), 32'h8);
    run_req(4, 1, 4'h0);
    run_req(5, 4, 4'h3);
    chk("tp_hi_q", 32'(bus.reg_q), 32'h8);
    chk("tp_hi_clip", 32'(bus.clip_cnt), 32'd1);
    run_req(1, 0, 4'h3);
    chk("tp_lo_q", 32'(bus.reg_q), 32'h9);
    chk("tp_lo_clip", 32'(bus.clip_cnt), 32'd1);
    run_req(-1, -2, 4'h3);
    chk("tp_out_q", 32'(bus.reg_q), 32'h9);
    chk("tp_out_clip", 32'(bus.clip_cnt), 32'd2);
    run_req(1, 3, 4'hF);
    run_req(5, 0, 4'hF);
    chk("tp_err_q", 32'(bus.reg_q), 32'h9);
    run_req(3, 3, 4'h0);

    // Abort a write after two bits with reset.
    run_req(4, 1, 4'h0);
    bus.req_valid = 1'b1;
    bus.req_msb   = 8'd4;
    bus.req_lsb   = 8'd1;
    bus.req_data  = 4'hF;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    chk("mid_q", 32'(bus.reg_q), 32'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_q", 32'(bus.reg_q), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    mq = '0;

    for (int t = 0; t < 40; t++) begin
      run_req(int'($urandom_range(10)) - 3, int'($urandom_range(10)) - 3,
              DW'($urandom));
    end

    // Back-to-back: request held, acceptances n+2 apart.
    bus.req_valid = 1'b1;
    bus.req_msb   = 8'd2;
    bus.req_lsb   = 8'd1;
    bus.req_data  = 4'h2;
    for (int c = 0; c < 18; c++) begin
      if (bus.req_ready) acc_cyc.push_back(c);
      tick();
    end
    bus.req_valid = 1'b0;
    chk("b2b_count", 32'(acc_cyc.size()), 32'd5);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      chk("b2b_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
    end
    wait_n = 0;
    while (!bus.req_ready && wait_n < 10) begin
      tick();
      wait_n++;
    end
    chk("b2b_drain", 32'(bus.req_ready), 32'd1);
    mq[1] = 1'b0;
    mq[2] = 1'b1;
    chk("b2b_q", 32'(bus.reg_q), 32'(mq));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mbit_sel_wr.md
# mbit_sel_wr

Sequential part-select writer: accepts a request to write a multi-bit field `[msb:lsb]` of a non-zero-based register `[HI:LO]` and commits it one bit per cycle. Out-of-range bit positions are dropped and counted rather than wrapped. It is the write-side counterpart of the part-select read diagnostics, including fields that straddle or fall fully outside the declared range (e.g. `[5:4]`, `[1:0]`, `[-1:-2]` on a `[4:1]` register). It sits in diag benches as the stimulus/target register for multi-bit select coverage.

## Interface

Parameters:
- `LO`, default 1, lowest declared bit index of the target register.
- `HI`, default 4, highest declared bit index of the target register (`HI >= LO`).
- `DW`, default 4, maximum field width and width of `req_data`.

Ports:
- `clock`, input, 1, single clock; all state updates on posedge.
- `reset`, input, 1, synchronous, active-high.
- `req_valid`, input, 1, request present.
- `req_ready`, output, 1, block can accept a request.
- `req_msb`, input, 8, field MSB index, signed two's complement.
- `req_lsb`, input, 8, field LSB index, signed two's complement.
- `req_data`, input, DW, field value; bit 0 maps to index `lsb`.
- `reg_q`, output, `[HI:LO]`, target register contents.
- `busy`, output, 1, write in progress (state WRITE).
- `done`, output, 1, one-cycle completion pulse.
- `err`, output, 1, valid only with `done`; request rejected, no bits written.
- `clip_cnt`, output, 4, valid only with `done`; number of field bits outside `[HI:LO]`.

## Operation

- FSM states: IDLE, WRITE, DONE.
- `req_ready = (state == IDLE)`.
- Handshake: accept on a posedge with `req_valid && req_ready`. At that edge, latch `msb`, `lsb`, `data`, set `k = lsb`, and clear `clip_cnt`.
- Request check at acceptance:
  - If `msb < lsb` (signed) or `msb - lsb + 1 > DW`: go IDLE→DONE, set `err = 1`, leave `reg_q` unchanged.
  - Otherwise go IDLE→WRITE with `err = 0`.
- WRITE, one bit per cycle:
  - If `LO <= k <= HI`: `reg_q[k] <= data[k - lsb]`.
  - Else: `clip_cnt <= clip_cnt + 1`, and `reg_q` is untouched.
  - Then `k <= k + 1`. When `k == msb`, go to DONE after that bit.
- DONE: `done = 1` for exactly one cycle, then IDLE. `err` and `clip_cnt` hold their values until the next acceptance.
- Bits of `reg_q` outside the field are never modified.
- A fully out-of-range field completes normally: `err = 0`, `clip_cnt` = field width, `reg_q` unchanged.
- Index arithmetic is signed, 9 bits wide internally, so negative indices and `k + 1` never wrap.
- `req_valid` while not ready is ignored; the requester must hold the request.

## Timing

- Reset values: `reg_q = 0`, state IDLE, `req_ready = 1` on the first cycle after the reset edge, `busy = 0`, `done = 0`, `err = 0`, `clip_cnt = 0`.
- With acceptance at edge E0 and `n = msb - lsb + 1`:
  - Bit `lsb + i` commits at edge E0+1+i.
  - `done` is high in the cycle after edge E0+n.
  - `req_ready` is high again after edge E0+n+1.
  - Throughput is one request per n+2 cycles.
- Error request: `done` and `err` are high in the cycle after E0; `req_ready` returns after E0+1.
- `busy` is high for exactly n cycles.
- `reset` in any state, including mid-WRITE: aborts the request, clears `reg_q` to 0, returns to IDLE with no `done` pulse. `reset` takes priority over a simultaneous handshake.
- Single-bit field (`msb == lsb`): n = 1.

## Test plan

- Reset, then write `[4:1] = 4'h4` → after 4 cycles `reg_q = 4'h4`; `done` at E0+4 with `err = 0`, `clip_cnt = 0`. Then write `[4:1] = 4'h8` → `reg_q = 4'h8`.
- From `reg_q = 4'h0`, write `[5:4] = 2'b11` → `reg_q = 4'h8`, `clip_cnt = 1`. Write `[1:0] = 2'b11` → `reg_q = 4'h9`, `clip_cnt = 1`.
- Write `[-1:-2] = 2'b11` → `reg_q` unchanged, `clip_cnt = 2`, `err = 0`, `done` after 2 write cycles.
- Write `[1:3]` (msb < lsb) and `[5:0]` (width 6 > DW) → `done` and `err` at E0+1, `reg_q` unchanged, `busy` never asserted.
- Start `[4:1] = 4'hF` from 0, assert `reset` after 2 bits → `reg_q = 0`, IDLE, no `done`, `req_ready = 1` on the next cycle.
- Hold `req_valid` high continuously with back-to-back requests → accepts occur only when `req_ready = 1`, and consecutive acceptances are exactly n+2 cycles apart.
